fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a FIFO with registered empty/data outputs.
// Each word is popped once and sent as: start bit, DATA_WIDTH bits LSB first, stop bit.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 139
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_re,
   output logic                  tx,
   output logic                  busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [IDX_W-1:0]      idx, idx_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic                  tx_n, busy_n, fifo_re_n;
   logic                  bit_done;

   assign bit_done = (cnt == CNT_LAST);

   always_comb begin
      // NOTE: every value written here gets a default first, so no latch is inferred.
      state_n   = state;
      cnt_n     = cnt;
      idx_n     = idx;
      shreg_n   = shreg;
      tx_n      = tx;
      busy_n    = busy;
      fifo_re_n = 1'b0;

      case (state)
         IDLE: begin
            cnt_n  = '0;
            idx_n  = '0;
            tx_n   = 1'b1;
            busy_n = 1'b0;
            if (!fifo_empty) begin
               shreg_n   = fifo_data;
               tx_n      = 1'b0;
               busy_n    = 1'b1;
               fifo_re_n = 1'b1;
               state_n   = START;
            end
         end
         START: begin
            cnt_n = cnt + 1'b1;
            if (bit_done) begin
               cnt_n   = '0;
               tx_n    = shreg[0];
               shreg_n = shreg >> 1;
               state_n = DATA;
            end
         end
         DATA: begin
            cnt_n = cnt + 1'b1;
            if (bit_done) begin
               cnt_n = '0;
               if (idx == IDX_LAST) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  idx_n   = idx + 1'b1;
                  tx_n    = shreg[0];
                  shreg_n = shreg >> 1;
               end
            end
         end
         STOP: begin
            cnt_n = cnt + 1'b1;
            if (bit_done) begin
               cnt_n   = '0;
               busy_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // The FIFO is sampled only in IDLE, so its slow flag/data update after a pop is harmless.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         fifo_re <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         tx      <= tx_n;
         busy    <= busy_n;
         fifo_re <= fifo_re_n;
      end
   end

endmodule
